// File: rtl/gf180_ram_pkg.sv
// Shared types and parameter defaults for the GF180 RAM wrapper.
package gf180_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

endpackage

// File: rtl/gf180_ram_init_seq.sv
// Post-reset clear sequencer: walks every implemented word once, then
// raises ready and stays there until the next reset.
//
// state    | meaning
// ST_INIT  | clearing word clr_addr this cycle, accesses rejected
// ST_READY | clear finished, accesses accepted
module gf180_ram_init_seq
  import gf180_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear one word per cycle; leave INIT after the last word is written.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_INIT: begin
        clr_we = 1'b1;
        if (cnt == LAST_WORD) begin
          state_nxt = ST_READY;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  assign clr_addr = cnt;
  assign ready    = (state == ST_READY);

endmodule

// File: rtl/gf180_ram_param_wrapper.sv
// Parameterised single-port RAM wrapper with bit-write mask, optional
// output register, self-clearing after reset and a sticky reject flag.
module gf180_ram_param_wrapper
  import gf180_ram_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int OUT_REG = 0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [DATA_W-1:0] WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              QVALID,
  output logic              READY,
  output logic              ERR
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range, acc_ok, wr_fire, rd_fire;
  logic [DATA_W-1:0] q_s1;
  logic              v_s1;

  gf180_ram_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk      (CLK),
    .rst_n    (RSTN),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (READY)
  );

  assign in_range = ({1'b0, A} < DEPTH_L);
  assign acc_ok   = !CEN && READY && in_range;
  assign wr_fire  = acc_ok && !GWEN;
  assign rd_fire  = acc_ok && GWEN;

  // Storage: zeroed by the clear sequencer, otherwise masked writes.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[A] <= (mem[A] & WEN) | (D & ~WEN);
    end
  end

  // First read stage: capture the addressed word, hold it otherwise.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_s1 <= '0;
      v_s1 <= 1'b0;
    end else begin
      v_s1 <= rd_fire;
      if (rd_fire) begin
        q_s1 <= mem[A];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] q_s2;
      logic              v_s2;

      // Optional output stage; advances every cycle so reads in flight drain.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          q_s2 <= '0;
          v_s2 <= 1'b0;
        end else begin
          v_s2 <= v_s1;
          if (v_s1) begin
            q_s2 <= q_s1;
          end
        end
      end

      assign Q      = q_s2;
      assign QVALID = v_s2;
    end else begin : g_no_out_reg
      assign Q      = q_s1;
      assign QVALID = v_s1;
    end
  endgenerate

  // Sticky flag for any access attempted before ready or out of range.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ERR <= 1'b0;
    end else if (!CEN && !(READY && in_range)) begin
      ERR <= 1'b1;
    end
  end

endmodule
